// File: rtl/lcd1602_byte_writer.sv
// HD44780/LCD1602 byte writer: one byte per valid/ready handshake,
// driven with setup, enable-pulse, hold and controller execution wait.
module lcd1602_byte_writer #(
  parameter int SETUP_CYC     = 4,
  parameter int EN_HIGH_CYC   = 25,
  parameter int HOLD_CYC      = 4,
  parameter int EXEC_CYC      = 2000,
  parameter int EXEC_LONG_CYC = 82000,
  parameter int CNT_W         = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_dat
);

  typedef enum logic [2:0] {
    IDLE, SETUP, EN_HI, HOLD, EXEC
  } state_t;

  localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_X     = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] L_XL    = CNT_W'(EXEC_LONG_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_long;
  logic             w_long;
  logic             w_zero;

  // clear (0x01) and home (0x02/0x03) need the long execution wait
  assign w_long = !in_rs && (in_data == 8'h01 ||
                             in_data == 8'h02 ||
                             in_data == 8'h03);
  assign w_zero = (r_cnt == '0);
  assign lcd_rw = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_long   <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_dat  <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            lcd_rs   <= in_rs;
            lcd_dat  <= in_data;
            r_long   <= w_long;
            in_ready <= 1'b0;
            r_cnt    <= L_SETUP;
            r_state  <= SETUP;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (w_zero) begin
            lcd_en  <= 1'b1;
            r_cnt   <= L_EN;
            r_state <= EN_HI;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        EN_HI: begin
          if (w_zero) begin
            lcd_en  <= 1'b0;
            r_cnt   <= L_HOLD;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (w_zero) begin
            r_cnt   <= r_long ? L_XL : L_X;
            r_state <= EXEC;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        EXEC: begin
          if (w_zero) begin
            done     <= 1'b1;
            in_ready <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd1602_byte_writer.sv
// Randomized bench for lcd1602_byte_writer against a cycle-offset
// reference model of the pin timing.
module tb_lcd1602_byte_writer;

  localparam int S  = 2;
  localparam int E  = 3;
  localparam int H  = 2;
  localparam int X  = 5;
  localparam int XL = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_dat;

  always #5 clk = ~clk;

  lcd1602_byte_writer #(
    .SETUP_CYC(S), .EN_HIGH_CYC(E), .HOLD_CYC(H),
    .EXEC_CYC(X), .EXEC_LONG_CYC(XL), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_data(in_data),
    .done(done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_dat(lcd_dat)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cyc", tag, got, exp);
    end
  endtask

  // model: time since accept drives every expected pin value
  bit         m_busy  = 0;
  bit         m_ready = 0;
  bit         m_done  = 0;
  bit         m_rs    = 0;
  logic [7:0] m_dat   = 8'h00;
  int         t       = 0;
  int         m_n     = 0;
  int         cyc     = 0;
  int         acc_cyc = 0;
  bit         last_acc = 0;
  int         n_acc   = 0;
  int         n_done  = 0;

  function automatic bit is_long(input logic rs, input logic [7:0] d);
    return !rs && (d >= 8'h01 && d <= 8'h03);
  endfunction

  task automatic step();
    bit acc;
    bit en_exp;
    @(posedge clk);
    acc = !rst && m_ready && in_valid;
    #1;
    cyc++;
    last_acc = acc;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_done = 0;
      m_rs = 0; m_dat = 8'h00;
    end else if (acc) begin
      m_busy = 1; t = 0; m_ready = 0; m_done = 0;
      m_rs = in_rs; m_dat = in_data;
      m_n = S + E + H + (is_long(in_rs, in_data) ? XL : X);
      acc_cyc = cyc; n_acc++;
    end else if (m_busy) begin
      t++;
      m_done = (t == m_n);
      if (t == m_n) begin
        m_busy = 0; m_ready = 1; n_done++;
      end
    end else begin
      m_ready = 1; m_done = 0;
    end
    en_exp = m_busy && t >= S && t < S + E;
    chk("ready", in_ready, m_ready);
    chk("done", done, m_done);
    chk("en", lcd_en, en_exp);
    chk("rs", lcd_rs, m_rs);
    chk("dat", lcd_dat, m_dat);
    chk("rw", lcd_rw, 1'b0);
  endtask

  task automatic send(input logic rs, input logic [7:0] d,
                      input bit hold);
    int n = 0;
    last_acc = 0;
    in_valid = 1'b1;
    while (!last_acc && n < 200) begin
      if (m_ready) begin
        in_rs = rs; in_data = d;
      end else begin
        in_rs = 1'($urandom); in_data = 8'($urandom);
      end
      step();
      n++;
    end
    if (!last_acc) chk("accept_timeout", 0, 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_rs = 1'($urandom); in_data = 8'($urandom);
      step();
    end
  endtask

  logic [7:0] stream [9] = '{8'h38, 8'h0C, 8'h06, 8'h01,
                             8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  bit         srs    [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    int prev_cyc;
    int prev_long;
    int d0;
    // reset and release
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", in_ready, 1'b1);
    idle(3);

    // single data byte, clear, 0x00, 0x0C
    d0 = n_done;
    send(1'b1, 8'h48, 0);
    idle(15);
    chk("h_done_count", n_done - d0, 1);
    send(1'b0, 8'h01, 0);
    idle(30);
    send(1'b0, 8'h00, 0);
    idle(15);
    send(1'b0, 8'h0C, 0);
    idle(15);

    // back-to-back stream with in_valid held
    prev_cyc = 0; prev_long = 0;
    for (int i = 0; i < 9; i++) begin
      send(srs[i], stream[i], 1);
      if (i > 0)
        chk("gap", acc_cyc - prev_cyc,
            S + E + H + (prev_long != 0 ? XL : X) + 1);
      prev_cyc  = acc_cyc;
      prev_long = is_long(srs[i], stream[i]);
    end
    in_valid = 1'b0;
    idle(15);

    // reset during the enable pulse
    d0 = n_done;
    send(1'b1, 8'h41, 0);
    while (t < S + 1) step();
    chk("en_before_rst", lcd_en, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(30);
    chk("no_done_after_rst", n_done - d0, 0);
    send(1'b1, 8'h42, 0);
    idle(15);

    // long idle holds the last byte
    idle(50);
    chk("idle_dat", lcd_dat, 8'h42);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_rs    = 1'($urandom);
      in_data  = ($urandom_range(0, 3) == 0) ?
                 8'($urandom_range(0, 3)) : 8'($urandom);
      step();
    end
    idle(30);
    chk("acc_vs_done", n_acc, n_done + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
